// File: rtl/k_alu_pkg.sv
// k_alu_pkg: shared constants for the k_alu execution stage.
//   DW          - datapath width (8)
//   OP_*        - 4-bit function select encodings
//   sh_mode_t   - barrel shifter mode
//   popcount()  - number of set bits, zero-extended to DW
package k_alu_pkg;

    localparam int DW = 8;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOR   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_INC   = 4'b1100;
    localparam logic [3:0] OP_DEC   = 4'b1101;
    localparam logic [3:0] OP_POPC  = 4'b1110;
    localparam logic [3:0] OP_PASSB = 4'b1111;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } sh_mode_t;

    function automatic logic [DW-1:0] popcount(input logic [DW-1:0] v);
        logic [DW-1:0] c;
        c = '0;
        for (int i = 0; i < DW; i++) begin
            c = c + {{(DW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/k_alu_shifter.sv
// k_alu_shifter: 3-stage logarithmic barrel shifter (combinational).
//   a    in  DW  shift source
//   amt  in  3   shift amount (0..7)
//   mode in  2   SH_SLL / SH_SRL / SH_SRA
//   y    out DW  shifted value
module k_alu_shifter
    import k_alu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [2:0]    amt,
    input  sh_mode_t      mode,
    output logic [DW-1:0] y
);

    logic          fill;
    logic [DW-1:0] l0, l1, l2;
    logic [DW-1:0] r0, r1, r2;

    // Right shifts share one chain; only the fill bit differs between SRL and SRA.
    assign fill = (mode == SH_SRA) & a[DW-1];

    assign l0 = amt[0] ? {a[DW-2:0], 1'b0}   : a;
    assign l1 = amt[1] ? {l0[DW-3:0], 2'b00} : l0;
    assign l2 = amt[2] ? {l1[DW-5:0], 4'h0}  : l1;

    assign r0 = amt[0] ? {fill, a[DW-1:1]}       : a;
    assign r1 = amt[1] ? {{2{fill}}, r0[DW-1:2]} : r0;
    assign r2 = amt[2] ? {{4{fill}}, r1[DW-1:4]} : r1;

    assign y = (mode == SH_SLL) ? l2 : r2;

endmodule

// File: rtl/k_alu.sv
// k_alu: 8-bit, 16-function registered ALU (1-cycle latency, 1 op/clock).
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   A    in   8  operand A / shift source
//   B    in   8  operand B / shift amount (B[2:0])
//   sel  in   4  function select (OP_* in k_alu_pkg)
//   res  out  8  registered result
//   zf   out  1  res == 0
//   cf   out  1  carry (ADD/INC) or borrow (SUB/DEC), else 0
//   vf   out  1  signed overflow for ADD/SUB/INC/DEC, else 0
//   nf   out  1  res[7]
module k_alu
    import k_alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic [3:0]    sel,
    output logic [DW-1:0] res,
    output logic          zf,
    output logic          cf,
    output logic          vf,
    output logic          nf
);

    logic          is_sub;
    logic          is_arith;
    logic [DW-1:0] b_op;
    logic [DW-1:0] add_b;
    logic [DW:0]   sum9;
    logic [DW-1:0] shift_y;
    sh_mode_t      sh_mode;
    logic [DW-1:0] res_d;
    logic          cf_d;
    logic          vf_d;

    // INC/DEC reuse the adder with an implicit operand of 1.
    assign b_op     = (sel == OP_INC || sel == OP_DEC) ? {{(DW-1){1'b0}}, 1'b1} : B;
    assign is_sub   = (sel == OP_SUB) || (sel == OP_DEC);
    assign is_arith = (sel == OP_ADD) || (sel == OP_SUB) ||
                      (sel == OP_INC) || (sel == OP_DEC);

    // Subtract as A + ~B + 1; bit 8 is then "no borrow", so it is inverted for cf.
    assign add_b = is_sub ? ~b_op : b_op;
    assign sum9  = {1'b0, A} + {1'b0, add_b} + {{DW{1'b0}}, is_sub};

    always_comb begin
        sh_mode = SH_SLL;
        case (sel)
            OP_SRL:  sh_mode = SH_SRL;
            OP_SRA:  sh_mode = SH_SRA;
            default: sh_mode = SH_SLL;
        endcase
    end

    k_alu_shifter u_shifter (
        .a    (A),
        .amt  (B[2:0]),
        .mode (sh_mode),
        .y    (shift_y)
    );

    always_comb begin
        res_d = '0;
        cf_d  = 1'b0;
        vf_d  = 1'b0;
        case (sel)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: res_d = sum9[DW-1:0];
            OP_AND:   res_d = A & B;
            OP_OR:    res_d = A | B;
            OP_XOR:   res_d = A ^ B;
            OP_NOR:   res_d = ~(A | B);
            OP_NOT:   res_d = ~A;
            OP_SLL, OP_SRL, OP_SRA: res_d = shift_y;
            OP_SLT:   res_d = {{(DW-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  res_d = {{(DW-1){1'b0}}, (A < B)};
            OP_POPC:  res_d = popcount(A);
            OP_PASSB: res_d = B;
            default:  res_d = '0;
        endcase
        if (is_arith) begin
            cf_d = sum9[DW] ^ is_sub;
            // Using the effective addend covers both the ADD and SUB overflow rules.
            vf_d = (A[DW-1] == add_b[DW-1]) && (sum9[DW-1] != A[DW-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            zf  <= 1'b1;
            cf  <= 1'b0;
            vf  <= 1'b0;
            nf  <= 1'b0;
        end else begin
            res <= res_d;
            zf  <= (res_d == '0);
            cf  <= cf_d;
            vf  <= vf_d;
            nf  <= res_d[DW-1];
        end
    end

endmodule

// File: tb/tb_k_alu.sv
module tb_k_alu;
    import k_alu_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] a, b;
    logic [3:0] sel;
    logic [7:0] res;
    logic       zf, cf, vf, nf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       zf;
        logic       cf;
        logic       vf;
        logic       nf;
    } vec_t;

    vec_t vq[$];
    vec_t sq[$];

    k_alu dut (
        .clk (clk),
        .rst (rst),
        .A   (a),
        .B   (b),
        .sel (sel),
        .res (res),
        .zf  (zf),
        .cf  (cf),
        .vf  (vf),
        .nf  (nf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic [3:0] s, logic [7:0] av, logic [7:0] bv,
                                logic [7:0] r, logic z, logic c, logic v, logic n);
        vec_t t;
        t.name = name; t.sel = s; t.a = av; t.b = bv;
        t.res = r; t.zf = z; t.cf = c; t.vf = v; t.nf = n;
        return t;
    endfunction

    task automatic check(string name, logic [7:0] er, logic ez, logic ec, logic ev, logic en);
        n_tests++;
        if ({res, zf, cf, vf, nf} !== {er, ez, ec, ev, en}) begin
            n_fail++;
            $display("FAIL %s: got res=%h z=%b c=%b v=%b n=%b, want res=%h z=%b c=%b v=%b n=%b",
                     name, res, zf, cf, vf, nf, er, ez, ec, ev, en);
        end
    endtask

    // Drive one operation, let it cross one edge, then check 1 ns later.
    task automatic apply(vec_t t);
        a = t.a; b = t.b; sel = t.sel;
        @(posedge clk);
        #1;
        check(t.name, t.res, t.zf, t.cf, t.vf, t.nf);
    endtask

    initial begin
        //                 name         sel       A      B      res    z  c  v  n
        vq.push_back(mk("and_6_78",   OP_AND,   8'h06, 8'h4E, 8'h06, 0, 0, 0, 0));
        vq.push_back(mk("add_6_78",   OP_ADD,   8'h06, 8'h4E, 8'h54, 0, 0, 0, 0));
        vq.push_back(mk("sub_6_78",   OP_SUB,   8'h06, 8'h4E, 8'hB8, 0, 1, 0, 1));
        vq.push_back(mk("add_ovf",    OP_ADD,   8'h7F, 8'h01, 8'h80, 0, 0, 1, 1));
        vq.push_back(mk("sll_3",      OP_SLL,   8'h96, 8'hFB, 8'hB0, 0, 0, 0, 1));
        vq.push_back(mk("srl_3",      OP_SRL,   8'h96, 8'hFB, 8'h12, 0, 0, 0, 0));
        vq.push_back(mk("sra_3",      OP_SRA,   8'h96, 8'hFB, 8'hF2, 0, 0, 0, 1));
        vq.push_back(mk("slt_fe_01",  OP_SLT,   8'hFE, 8'h01, 8'h01, 0, 0, 0, 0));
        vq.push_back(mk("sltu_fe_01", OP_SLTU,  8'hFE, 8'h01, 8'h00, 1, 0, 0, 0));
        vq.push_back(mk("popc_b7",    OP_POPC,  8'hB7, 8'h00, 8'h06, 0, 0, 0, 0));
        vq.push_back(mk("inc_ff",     OP_INC,   8'hFF, 8'h55, 8'h00, 1, 1, 0, 0));
        vq.push_back(mk("dec_80",     OP_DEC,   8'h80, 8'h55, 8'h7F, 0, 0, 1, 0));
        vq.push_back(mk("or",         OP_OR,    8'h0F, 8'h30, 8'h3F, 0, 0, 0, 0));
        vq.push_back(mk("xor",        OP_XOR,   8'hFF, 8'h0F, 8'hF0, 0, 0, 0, 1));
        vq.push_back(mk("nor",        OP_NOR,   8'h0F, 8'h30, 8'hC0, 0, 0, 0, 1));
        vq.push_back(mk("not",        OP_NOT,   8'h5A, 8'hFF, 8'hA5, 0, 0, 0, 1));
        vq.push_back(mk("passb_0",    OP_PASSB, 8'hAA, 8'h00, 8'h00, 1, 0, 0, 0));
        vq.push_back(mk("sub_eq",     OP_SUB,   8'h05, 8'h05, 8'h00, 1, 0, 0, 0));
        vq.push_back(mk("sub_ovf",    OP_SUB,   8'h80, 8'h01, 8'h7F, 0, 0, 1, 0));
        vq.push_back(mk("add_carry",  OP_ADD,   8'hFF, 8'h01, 8'h00, 1, 1, 0, 0));
        vq.push_back(mk("add_80_80",  OP_ADD,   8'h80, 8'h80, 8'h00, 1, 1, 1, 0));
        vq.push_back(mk("sll_7",      OP_SLL,   8'h01, 8'h07, 8'h80, 0, 0, 0, 1));
        vq.push_back(mk("sra_amt0",   OP_SRA,   8'h80, 8'h08, 8'h80, 0, 0, 0, 1));
        vq.push_back(mk("srl_7",      OP_SRL,   8'h80, 8'hFF, 8'h01, 0, 0, 0, 0));
        vq.push_back(mk("slt_7f_80",  OP_SLT,   8'h7F, 8'h80, 8'h00, 1, 0, 0, 0));
        vq.push_back(mk("sltu_7f_80", OP_SLTU,  8'h7F, 8'h80, 8'h01, 0, 0, 0, 0));
        vq.push_back(mk("dec_00",     OP_DEC,   8'h00, 8'h00, 8'hFF, 0, 1, 0, 1));
        vq.push_back(mk("popc_ff",    OP_POPC,  8'hFF, 8'h00, 8'h08, 0, 0, 0, 0));
        vq.push_back(mk("popc_00",    OP_POPC,  8'h00, 8'hFF, 8'h00, 1, 0, 0, 0));

        // Back-to-back sweep of all 16 codes with A=C5, B=3A (shift amount 2).
        sq.push_back(mk("s_add",   OP_ADD,   8'hC5, 8'h3A, 8'hFF, 0, 0, 0, 1));
        sq.push_back(mk("s_sub",   OP_SUB,   8'hC5, 8'h3A, 8'h8B, 0, 0, 0, 1));
        sq.push_back(mk("s_and",   OP_AND,   8'hC5, 8'h3A, 8'h00, 1, 0, 0, 0));
        sq.push_back(mk("s_or",    OP_OR,    8'hC5, 8'h3A, 8'hFF, 0, 0, 0, 1));
        sq.push_back(mk("s_xor",   OP_XOR,   8'hC5, 8'h3A, 8'hFF, 0, 0, 0, 1));
        sq.push_back(mk("s_nor",   OP_NOR,   8'hC5, 8'h3A, 8'h00, 1, 0, 0, 0));
        sq.push_back(mk("s_not",   OP_NOT,   8'hC5, 8'h3A, 8'h3A, 0, 0, 0, 0));
        sq.push_back(mk("s_sll",   OP_SLL,   8'hC5, 8'h3A, 8'h14, 0, 0, 0, 0));
        sq.push_back(mk("s_srl",   OP_SRL,   8'hC5, 8'h3A, 8'h31, 0, 0, 0, 0));
        sq.push_back(mk("s_sra",   OP_SRA,   8'hC5, 8'h3A, 8'hF1, 0, 0, 0, 1));
        sq.push_back(mk("s_slt",   OP_SLT,   8'hC5, 8'h3A, 8'h01, 0, 0, 0, 0));
        sq.push_back(mk("s_sltu",  OP_SLTU,  8'hC5, 8'h3A, 8'h00, 1, 0, 0, 0));
        sq.push_back(mk("s_inc",   OP_INC,   8'hC5, 8'h3A, 8'hC6, 0, 0, 0, 1));
        sq.push_back(mk("s_dec",   OP_DEC,   8'hC5, 8'h3A, 8'hC4, 0, 0, 0, 1));
        sq.push_back(mk("s_popc",  OP_POPC,  8'hC5, 8'h3A, 8'h04, 0, 0, 0, 0));
        sq.push_back(mk("s_passb", OP_PASSB, 8'hC5, 8'h3A, 8'h3A, 0, 0, 0, 0));

        // Reset for two cycles with all-ones operands.
        rst = 1'b1; a = 8'hFF; b = 8'hFF; sel = OP_ADD;
        @(posedge clk); #1;
        check("reset_c1", 8'h00, 1, 0, 0, 0);
        @(posedge clk); #1;
        check("reset_c2", 8'h00, 1, 0, 0, 0);
        rst = 1'b0;

        foreach (vq[i]) apply(vq[i]);

        // Result holds between edges while inputs change.
        a = 8'h12; b = 8'h34; sel = OP_PASSB;
        #3;
        check("hold_prev", vq[vq.size()-1].res, vq[vq.size()-1].zf, 0, 0, 0);

        for (int i = 0; i < sq.size(); i++) apply(sq[i]);

        // Same sweep again, with a one-cycle reset landing on the SRL slot.
        for (int i = 0; i < sq.size(); i++) begin
            if (i == 8) begin
                rst = 1'b1;
                a = sq[i].a; b = sq[i].b; sel = sq[i].sel;
                @(posedge clk); #1;
                check("mid_reset", 8'h00, 1, 0, 0, 0);
                rst = 1'b0;
            end
            apply(sq[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
